counter_seq_ctrl: RTL
=====================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter MAX_COUNT_CYCLES, default 16, watchdog limit on COUNT-state cycles per command.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; asserted while 0.
REQ-004 req_valid  in  2  per-requester command valid, index 0/1.
REQ-005 req_start  in  2x4  per-requester start value.
REQ-006 req_target  in  2x4  per-requester target value.
REQ-007 req_ready  out  2  per-requester accept strobe, one-hot or zero.
REQ-008 cnt_load  out  1  counter load control.
REQ-009 cnt_data_in  out  4  counter load value.
REQ-010 cnt_up_down  out  1  counter direction, 1 = up.
REQ-011 cnt_data_out  in  4  registered counter value.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse on command completion.
REQ-014 done_id  out  1  requester index of the completed or aborted command, valid with done/err.
REQ-015 err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-016 FSM states: IDLE, LOAD, COUNT; reset state IDLE.
REQ-017 IDLE: cnt_load=1, cnt_data_in=hold_q (freezes the counter); hold_q resets to 0.
REQ-018 IDLE with any req_valid: round-robin grant; req_ready[g]=1 that cycle; capture start, target, id=g; next state LOAD.
REQ-019 Round-robin: both valid -> grant the index not granted last; last-grant resets to 1, so requester 0 wins first.
REQ-020 Direction captured at accept: up if target>start, else down; no wrap-around path is ever used.
REQ-021 req_valid must hold until req_ready; only IDLE asserts req_ready; requests are ignored in LOAD and COUNT.
REQ-022 LOAD (one cycle): cnt_load=1, cnt_data_in=start; next state COUNT.
REQ-023 COUNT, cnt_data_out!=target: cnt_load=0, cnt_up_down=dir, increment watchdog.
REQ-024 COUNT, cnt_data_out==target (Mealy): cnt_load=1, cnt_data_in=target, done=1, done_id=id, hold_q<=target, next state IDLE.
REQ-025 start==target: done in the first COUNT cycle.
REQ-026 Latency from the req_ready cycle to the done cycle is |target-start|+2 cycles.
REQ-027 Watchdog reaches MAX_COUNT_CYCLES in COUNT without a match: cnt_load=1, cnt_data_in=cnt_data_out, err=1, done=0, hold_q<=cnt_data_out, next state IDLE.
REQ-028 Match and watchdog in the same cycle: match wins (done, no err).
REQ-029 done and err are never high together.

Reset
REQ-030 Reset asserted (at any time, including mid-command) forces IDLE, hold_q=0, watchdog=0, last-grant=1, captured command cleared.
REQ-031 Output values during reset: req_ready=0, busy=0, done=0, err=0, done_id=0, cnt_load=1, cnt_data_in=0, cnt_up_down=0.

Structure
REQ-032 Package counter_ctrl_pkg holds the state enum, the 4-bit count width constant, and the command struct {start, target, dir, id}.
REQ-033 Sub-module rr_arbiter_2 holds the two-requester round-robin grant and its last-grant register.

Verification
REQ-034 Req0 start=3 target=9 -> ready0 once; LOAD data_in=3; done with done_id=0 exactly 8 cycles after ready; counter holds 9 afterwards.
REQ-035 Req1 start=12 target=2 -> cnt_up_down=0 throughout COUNT; done after 12 cycles; counter holds 2.
REQ-036 Both valid continuously -> grants alternate 0,1,0,1; no req_ready while busy.
REQ-037 start=5 target=5 -> done 2 cycles after ready; no counting cycles.
REQ-038 Counter model stuck (never advances), MAX_COUNT_CYCLES=16 -> err pulse, done=0, IDLE, counter held at its stuck value.
REQ-039 Reset asserted mid-COUNT at value 7 -> immediate IDLE, busy=0, cnt_load=1, cnt_data_in=0; counter reads 0 after release.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for the counter sequencing controller
package counter_ctrl_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COUNT
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0] start;
      logic [CNT_W-1:0] target;
      logic             dir;
      logic             id;
   } cmd_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// rtl/counter_seq_ctrl_if.sv - two-requester command handshake bundle
interface counter_seq_ctrl_if;
   import counter_ctrl_pkg::*;

   logic [1:0]            req_valid;
   logic [1:0][CNT_W-1:0] req_start;
   logic [1:0][CNT_W-1:0] req_target;
   logic [1:0]            req_ready;

   modport master (output req_valid, output req_start, output req_target, input req_ready);
   modport slave  (input req_valid, input req_start, input req_target, output req_ready);
endinterface

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-requester round-robin grant with last-grant memory
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_q;

   // On contention grant the requester that did not win last time.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      last_q <= 1'b1;
      else if (gnt[0]) last_q <= 1'b0;
      else if (gnt[1]) last_q <= 1'b1;
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - sequences an external up/down counter from start to target per command
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int MAX_COUNT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   counter_seq_ctrl_if.slave req_if,
   output logic             cnt_load,
   output logic [CNT_W-1:0] cnt_data_in,
   output logic             cnt_up_down,
   input  logic [CNT_W-1:0] cnt_data_out,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic             err
);

   localparam int WD_W = $clog2(MAX_COUNT_CYCLES + 1);

   state_t           state_q, state_d;
   cmd_t             cmd_q;
   logic [CNT_W-1:0] hold_q;
   logic [WD_W-1:0]  wd_q;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             match;
   logic             wd_exp;

   assign match  = (cnt_data_out == cmd_q.target);
   // Expires on the last allowed COUNT cycle, so a full 15-step run still matches in time.
   assign wd_exp = (wd_q >= WD_W'(MAX_COUNT_CYCLES - 1));
   assign gnt_id = gnt[1];

   rr_arbiter_2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (state_q == ST_IDLE),
      .req   (req_if.req_valid),
      .gnt   (gnt)
   );

   assign req_if.req_ready = gnt;
   assign done_id          = cmd_q.id;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|gnt) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_COUNT;
         ST_COUNT: if (match || wd_exp) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_load    = 1'b1;
      cnt_data_in = hold_q;
      cnt_up_down = cmd_q.dir;
      busy        = (state_q != ST_IDLE);
      done        = 1'b0;
      err         = 1'b0;
      case (state_q)
         ST_LOAD:  cnt_data_in = cmd_q.start;
         ST_COUNT: begin
            if (match) begin
               cnt_data_in = cmd_q.target;
               done        = 1'b1;
            end else if (wd_exp) begin
               cnt_data_in = cnt_data_out;
               err         = 1'b1;
            end else begin
               cnt_load    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_q  <= '0;
         hold_q <= '0;
         wd_q   <= '0;
      end else begin
         if (state_q == ST_IDLE && (|gnt)) begin
            cmd_q.start  <= req_if.req_start[gnt_id];
            cmd_q.target <= req_if.req_target[gnt_id];
            cmd_q.dir    <= (req_if.req_target[gnt_id] > req_if.req_start[gnt_id]);
            cmd_q.id     <= gnt_id;
         end
         if (state_q != ST_COUNT)      wd_q <= '0;
         else if (!match && !wd_exp)   wd_q <= wd_q + 1'b1;
         // cnt_data_in already carries target or the frozen value on exit.
         if (state_q == ST_COUNT && (match || wd_exp)) hold_q <= cnt_data_in;
      end
   end

endmodule
